laser_uart_link: RTL and testbench
==================================

Name: laser_uart_link

Overview:
- UART bridge between the command path and the external laser controller.
- TX side: accepts 32-bit laser command words from the command decoder and serialises each as 4 UART bytes.
- RX side: deserialises UART bytes from the laser and delivers them as a byte stream with a frame-last marker, for the arbiter that forwards replies to the main PC.
- Single clock domain; UART 8N1 framing.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, UART bit rate.
- TX_FIFO_DEPTH, 4, number of queued 32-bit command words.
- RX_IDLE_BITS, 20, idle bit-times on RXD that close an RX frame.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- laser_tx_data_i  in  32  command word to transmit.
- laser_tx_vld_i  in  1  one-cycle strobe; captures laser_tx_data_i.
- laser_rx_data_o  out  8  received byte.
- laser_rx_vld_o  out  1  one-cycle strobe; laser_rx_data_o is valid.
- laser_rx_last_o  out  1  high together with laser_rx_vld_o on the final byte of a frame.
- LASER_UART_RXD  in  1  serial input from the laser; asynchronous; idle high.
- LASER_UART_TXD  out  1  serial output to the laser; idle high.

Behaviour:
- Bit period: BIT_CNT = CLK_FREQ/BAUD clocks, integer division (10416 at the defaults).
- Reset values: LASER_UART_TXD=1, laser_rx_data_o=0, laser_rx_vld_o=0, laser_rx_last_o=0. FIFO empty; both FSMs IDLE; pending-byte flag cleared.
- Reset asserted mid-byte aborts immediately. TXD returns high within the same cycle. No partial RX byte is delivered.
- TX FIFO:
  - Each laser_tx_vld_i pulse writes one word.
  - A write while the FIFO is full is dropped; FIFO contents are unchanged.
  - Simultaneous write and read are both honoured.
- TX FSM states: IDLE, START, DATA, STOP, NEXT.
  - IDLE: if the FIFO is not empty, pop a word into the shift register, set byte index to 3, go to START.
  - START: TXD=0 for BIT_CNT clocks.
  - DATA: 8 bits LSB-first, each held BIT_CNT clocks.
  - STOP: TXD=1 for BIT_CNT clocks.
  - NEXT: if byte index > 0, decrement it and go to START; otherwise go to IDLE.
  - Byte order is [31:24], [23:16], [15:8], [7:0].
  - No gap between bytes within a word. Back-to-back words add at most 2 clocks of idle.
- TX latency: the first start-bit edge on TXD occurs within 3 clocks of the laser_tx_vld_i that wrote an empty FIFO while the FSM is IDLE.
- RX input: LASER_UART_RXD passes through a 2-flop synchroniser before any use.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge goes to START.
  - START: re-sample at BIT_CNT/2. If low, continue; if high, it is a glitch, return to IDLE.
  - DATA: sample 8 bits at bit centres, LSB-first.
  - STOP: sample at the centre. If high, the byte is good. If low, it is a framing error: discard the byte and wait for RXD high before returning to IDLE.
- RX framing via a one-byte holding register:
  - A good byte arriving while a byte is pending emits the pending byte (vld=1, last=0), then stores the new byte as pending.
  - A good byte arriving with nothing pending is stored as pending.
  - An idle counter counts clocks while the RX FSM is IDLE and a byte is pending. It clears when a start bit is detected.
  - When the counter reaches RX_IDLE_BITS*BIT_CNT, the pending byte is emitted with vld=1, last=1 and the pending flag clears.
  - laser_rx_vld_o and laser_rx_last_o are single-cycle pulses; laser_rx_data_o holds its value until the next vld.
  - A frame of N bytes yields exactly N vld pulses, and last is set only on the Nth.
- TX and RX are fully independent; a full-duplex loopback must work.

Test Plan:
- Single TX word: pulse vld with 0x41_42_43_0D -> TXD carries bytes 0x41, 0x42, 0x43, 0x0D in that order. Each frame is 1 start + 8 data + 1 stop bit, 10416 clocks per bit; TXD is high afterwards.
- TX queue overflow: 6 vld pulses on consecutive cycles, data 1..6 -> words 1..5 are transmitted (1 in the shift register plus 4 queued), word 6 is dropped, total 20 bytes.
- RX frame: the bench UART sends 16 bytes 0x00..0x0F back-to-back at 9600 baud, then stays idle -> 16 vld pulses with data 0x00..0x0F. last=1 only with 0x0F, about 20 bit-times after its stop bit.
- RX two frames: 3 bytes, 30 bit-times idle, 2 bytes -> last pulses on the 3rd and 5th bytes only.
- RX glitch/framing: a 1000-clock low pulse on RXD gives no output; a byte with its stop bit forced low is discarded and the following valid byte is received correctly.
- Reset mid-transfer: assert rst_n=0 during TX DATA and RX DATA -> TXD=1 and all outputs 0 immediately. After release, no spurious vld appears and the next word transmits intact.

Source files
------------

// File: rtl/laser_uart_link.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : laser_uart_link
// Purpose  : UART 8N1 bridge to the external laser controller. The TX side
//            queues 32-bit command words and sends each as 4 bytes, MSB byte
//            first. The RX side delivers received bytes with a frame-last
//            marker that is raised after an idle gap on the line.
// Revision : 1.0 - initial release
// ============================================================================
module laser_uart_link #(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int BAUD          = 9600,
    parameter int TX_FIFO_DEPTH = 4,
    parameter int RX_IDLE_BITS  = 20
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [31:0] laser_tx_data_i,
    input  logic        laser_tx_vld_i,
    output logic [7:0]  laser_rx_data_o,
    output logic        laser_rx_vld_o,
    output logic        laser_rx_last_o,
    input  logic        LASER_UART_RXD,
    output logic        LASER_UART_TXD
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int c_BIT_CNT  = CLK_FREQ / BAUD;
    localparam int c_CNT_W    = $clog2(c_BIT_CNT + 1);
    localparam int c_IDLE_CNT = RX_IDLE_BITS * c_BIT_CNT;
    localparam int c_IDLE_W   = $clog2(c_IDLE_CNT + 1);
    localparam int c_PTR_W    = (TX_FIFO_DEPTH > 1) ? $clog2(TX_FIFO_DEPTH) : 1;
    localparam int c_FCNT_W   = $clog2(TX_FIFO_DEPTH + 1);

    localparam logic [c_CNT_W-1:0]  c_BIT_LAST  = c_CNT_W'(c_BIT_CNT - 1);
    localparam logic [c_CNT_W-1:0]  c_HALF_LAST = c_CNT_W'(c_BIT_CNT / 2 - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(c_IDLE_CNT - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_ONE  = c_IDLE_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_LAST  = c_PTR_W'(TX_FIFO_DEPTH - 1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_FCNT_W-1:0] c_FIFO_FULL = c_FCNT_W'(TX_FIFO_DEPTH);
    localparam logic [c_FCNT_W-1:0] c_FCNT_ONE  = c_FCNT_W'(1);

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd3,
        TX_NEXT  = 3'd4
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // ------------------------------------------------------------------
    // TX command FIFO
    // ------------------------------------------------------------------
    logic [31:0]         r_fifo_mem [TX_FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_FCNT_W-1:0] r_fifo_cnt;
    tx_state_t           r_tx_state;

    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_fifo_wr;
    logic w_fifo_rd;

    assign w_fifo_full  = (r_fifo_cnt == c_FIFO_FULL);
    assign w_fifo_empty = (r_fifo_cnt == '0);
    // Writes into a full FIFO are silently dropped.
    assign w_fifo_wr    = laser_tx_vld_i && !w_fifo_full;
    // The TX FSM pops exactly when it leaves IDLE.
    assign w_fifo_rd    = (r_tx_state == TX_IDLE) && !w_fifo_empty;

    // Storage array; no reset needed since occupancy is tracked separately.
    always_ff @(posedge clk_i) begin
        if (w_fifo_wr) begin
            r_fifo_mem[r_wr_ptr] <= laser_tx_data_i;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop may coincide.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_ONE;
            end
            if (w_fifo_rd) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;
            end
            case ({w_fifo_wr, w_fifo_rd})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + c_FCNT_ONE;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - c_FCNT_ONE;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX serialiser
    // ------------------------------------------------------------------
    logic [31:0]        r_tx_word;
    logic [6:0]         r_tx_sh;
    logic [2:0]         r_tx_bit;
    logic [1:0]         r_tx_idx;
    logic [c_CNT_W-1:0] r_tx_cnt;
    logic               r_txd;

    // TX FSM with registered line output. The start bit of a following byte
    // is driven from the last stop-bit clock so NEXT costs no line time.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_word  <= '0;
            r_tx_sh    <= '0;
            r_tx_bit   <= '0;
            r_tx_idx   <= '0;
            r_tx_cnt   <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_txd <= 1'b1;
                    if (!w_fifo_empty) begin
                        r_tx_word  <= r_fifo_mem[r_rd_ptr];
                        r_tx_idx   <= 2'd3;
                        r_tx_cnt   <= '0;
                        r_txd      <= 1'b0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == c_BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_txd      <= r_tx_word[24];
                        r_tx_sh    <= r_tx_word[31:25];
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == c_BIT_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_txd      <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_bit <= r_tx_bit + 3'd1;
                            r_txd    <= r_tx_sh[0];
                            r_tx_sh  <= {1'b0, r_tx_sh[6:1]};
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_CNT_ONE;
                    end
                end
                TX_STOP: begin
                    if (r_tx_cnt == c_BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_txd      <= (r_tx_idx == 2'd0);
                        r_tx_state <= TX_NEXT;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_CNT_ONE;
                    end
                end
                TX_NEXT: begin
                    if (r_tx_idx != 2'd0) begin
                        r_tx_idx   <= r_tx_idx - 2'd1;
                        r_tx_word  <= {r_tx_word[23:0], 8'h00};
                        r_tx_cnt   <= c_CNT_ONE;
                        r_tx_state <= TX_START;
                    end else begin
                        r_tx_state <= TX_IDLE;
                    end
                end
                default: begin
                    r_txd      <= 1'b1;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign LASER_UART_TXD = r_txd;

    // ------------------------------------------------------------------
    // RX deserialiser
    // ------------------------------------------------------------------
    logic               r_rxd_meta;
    logic               r_rxd_sync;
    logic               r_rxd_prev;
    rx_state_t          r_rx_state;
    logic [c_CNT_W-1:0] r_rx_cnt;
    logic [2:0]         r_rx_bit;
    logic [7:0]         r_rx_sh;
    logic               r_rx_ferr;
    logic               r_rx_good;
    logic               w_rx_fall;

    // Two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_meta <= LASER_UART_RXD;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    assign w_rx_fall = r_rxd_prev && !r_rxd_sync;

    // RX FSM: mid-bit sampling; r_rx_good pulses once per byte with a valid
    // stop bit. After a framing error it parks in STOP until the line is high.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_sh    <= '0;
            r_rx_ferr  <= 1'b0;
            r_rx_good  <= 1'b0;
        end else begin
            r_rx_good <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_ferr <= 1'b0;
                    if (w_rx_fall) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == c_HALF_LAST) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_state <= r_rxd_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == c_BIT_LAST) begin
                        r_rx_cnt <= '0;
                        r_rx_sh  <= {r_rxd_sync, r_rx_sh[7:1]};
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 3'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (r_rx_ferr) begin
                        if (r_rxd_sync) begin
                            r_rx_state <= RX_IDLE;
                        end
                    end else if (r_rx_cnt == c_BIT_LAST) begin
                        r_rx_cnt <= '0;
                        if (r_rxd_sync) begin
                            r_rx_good  <= 1'b1;
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_ferr <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_CNT_ONE;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX framing: one byte is held back so the last byte of a frame can be
    // tagged once the line has been idle long enough.
    // ------------------------------------------------------------------
    logic [7:0]          r_pend_byte;
    logic                r_pend;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic [7:0]          r_rx_data;
    logic                r_rx_vld;
    logic                r_rx_last;

    // Holding register, idle timer and output strobes.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_byte <= '0;
            r_pend      <= 1'b0;
            r_idle_cnt  <= '0;
            r_rx_data   <= '0;
            r_rx_vld    <= 1'b0;
            r_rx_last   <= 1'b0;
        end else begin
            r_rx_vld  <= 1'b0;
            r_rx_last <= 1'b0;
            if (r_rx_good) begin
                if (r_pend) begin
                    r_rx_data <= r_pend_byte;
                    r_rx_vld  <= 1'b1;
                end
                r_pend_byte <= r_rx_sh;
                r_pend      <= 1'b1;
                r_idle_cnt  <= '0;
            end else if ((r_rx_state == RX_IDLE) && w_rx_fall) begin
                r_idle_cnt <= '0;
            end else if (r_pend && (r_rx_state == RX_IDLE)) begin
                if (r_idle_cnt == c_IDLE_LAST) begin
                    r_rx_data  <= r_pend_byte;
                    r_rx_vld   <= 1'b1;
                    r_rx_last  <= 1'b1;
                    r_pend     <= 1'b0;
                    r_idle_cnt <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + c_IDLE_ONE;
                end
            end
        end
    end

    assign laser_rx_data_o = r_rx_data;
    assign laser_rx_vld_o  = r_rx_vld;
    assign laser_rx_last_o = r_rx_last;

endmodule
`default_nettype wire

// File: tb/tb_laser_uart_link.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : tb_laser_uart_link
// Purpose  : Directed self-checking bench for laser_uart_link. Runs with a
//            16-clock bit period so whole frames fit in a short simulation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_laser_uart_link;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD      = 62_500;
    localparam int BIT       = CLK_FREQ / BAUD;   // 16 clocks per bit
    localparam int IDLE_BITS = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx_vld = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic        rx_last;
    logic        rxd = 1'b1;
    logic        txd;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stray_last = 0;

    logic [8:0] rxq [$];
    int         rxt [$];

    always #5 clk = ~clk;

    laser_uart_link #(
        .CLK_FREQ      (CLK_FREQ),
        .BAUD          (BAUD),
        .TX_FIFO_DEPTH (4),
        .RX_IDLE_BITS  (IDLE_BITS)
    ) u_dut (
        .clk_i           (clk),
        .rst_n           (rst_n),
        .laser_tx_data_i (tx_data),
        .laser_tx_vld_i  (tx_vld),
        .laser_rx_data_o (rx_data),
        .laser_rx_vld_o  (rx_vld),
        .laser_rx_last_o (rx_last),
        .LASER_UART_RXD  (rxd),
        .LASER_UART_TXD  (txd)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record every delivered byte as {last, data} with its cycle stamp.
    always @(negedge clk) begin
        if (rx_vld === 1'b1) begin
            rxq.push_back({rx_last, rx_data});
            rxt.push_back(cyc);
        end
        if (rx_last === 1'b1 && rx_vld !== 1'b1) stray_last++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bench-side UART transmitter driving RXD.
    task automatic uart_send(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(BIT);
        end
        rxd = stop;
        tick(BIT);
        rxd = 1'b1;
    endtask

    // Bench-side UART receiver on TXD. With in_bit0 set the caller is already
    // half a clock into data bit 0. ok drops on timeout, bad start or stop.
    task automatic uart_recv(input bit in_bit0, output logic [7:0] b, output logic ok);
        int n;
        ok = 1'b1;
        b  = '0;
        if (!in_bit0) begin
            n = 0;
            while (txd !== 1'b0 && n < 400) begin
                @(negedge clk);
                n++;
            end
            if (txd !== 1'b0) begin
                ok = 1'b0;
                return;
            end
            tick(BIT / 2);
            if (txd !== 1'b0) ok = 1'b0;
            tick(BIT);
        end else begin
            tick(BIT / 2);
        end
        b[0] = txd;
        for (int i = 1; i < 8; i++) begin
            tick(BIT);
            b[i] = txd;
        end
        tick(BIT);
        if (txd !== 1'b1) ok = 1'b0;
    endtask

    initial begin
        int          lat;
        int          lo;
        int          t_end;
        int          delta;
        logic [7:0]  b;
        logic        ok;
        logic [31:0] exp_word;
        logic [4:0]  lasts;

        // ---------------- reset values ----------------
        tick(2);
        chk("reset_txd", {31'b0, txd}, 32'd1);
        chk("reset_rx_data", {24'b0, rx_data}, 32'h0);
        chk("reset_rx_vld_last", {30'b0, rx_vld, rx_last}, 32'h0);
        rst_n = 1'b1;
        tick(4);

        // ---------------- single TX word ----------------
        tx_data = 32'h4142_430D;
        tx_vld  = 1'b1;
        tick(1);
        tx_vld  = 1'b0;
        lat = 0;
        while (txd !== 1'b0 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("tx_latency_le3", {31'b0, (lat >= 1 && lat <= 3)}, 32'd1);
        lo = 0;
        while (txd === 1'b0 && lo < 100) begin
            lo++;
            @(negedge clk);
        end
        chk("tx_start_bit_clocks", lo, BIT);
        uart_recv(1'b1, b, ok);
        chk("tx_word_byte0", {23'b0, ok, b}, {23'b0, 1'b1, 8'h41});
        uart_recv(1'b0, b, ok);
        chk("tx_word_byte1", {23'b0, ok, b}, {23'b0, 1'b1, 8'h42});
        uart_recv(1'b0, b, ok);
        chk("tx_word_byte2", {23'b0, ok, b}, {23'b0, 1'b1, 8'h43});
        uart_recv(1'b0, b, ok);
        chk("tx_word_byte3", {23'b0, ok, b}, {23'b0, 1'b1, 8'h0D});
        lo = 0;
        for (int i = 0; i < 4 * BIT; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lo++;
        end
        chk("tx_idle_after_word", lo, 0);

        // ---------------- TX queue overflow ----------------
        for (int k = 1; k <= 6; k++) begin
            tx_data = k;
            tx_vld  = 1'b1;
            tick(1);
        end
        tx_vld = 1'b0;
        for (int w = 1; w <= 5; w++) begin
            exp_word = w;
            for (int j = 3; j >= 0; j--) begin
                uart_recv(1'b0, b, ok);
                chk($sformatf("tx_ovf_w%0d_b%0d", w, 3 - j), {23'b0, ok, b},
                    {23'b0, 1'b1, exp_word[8*j +: 8]});
            end
        end
        lo = 0;
        for (int i = 0; i < 25 * BIT; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lo++;
        end
        chk("tx_ovf_word6_dropped", lo, 0);

        // ---------------- RX 16-byte frame ----------------
        rxq.delete();
        rxt.delete();
        for (int i = 0; i < 16; i++) uart_send(8'(i), 1'b1);
        t_end = cyc;
        chk("rx16_held_back_count", rxq.size(), 15);
        tick((IDLE_BITS + 4) * BIT);
        chk("rx16_count", rxq.size(), 16);
        if (rxq.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("rx16_item%0d", i), {23'b0, rxq[i]},
                    {23'b0, (i == 15), 8'(i)});
            end
            delta = rxt[15] - t_end;
            chk("rx16_last_gap_near_20_bits",
                {31'b0, (delta >= (IDLE_BITS - 1) * BIT && delta <= (IDLE_BITS + 1) * BIT)}, 32'd1);
        end

        // ---------------- RX two frames ----------------
        rxq.delete();
        rxt.delete();
        uart_send(8'hA0, 1'b1);
        uart_send(8'hA1, 1'b1);
        uart_send(8'hA2, 1'b1);
        tick(30 * BIT);
        uart_send(8'hB0, 1'b1);
        uart_send(8'hB1, 1'b1);
        tick((IDLE_BITS + 4) * BIT);
        chk("rx2f_count", rxq.size(), 5);
        if (rxq.size() == 5) begin
            lasts = '0;
            for (int i = 0; i < 5; i++) lasts[i] = rxq[i][8];
            chk("rx2f_last_pattern", {27'b0, lasts}, 32'b10100);
            chk("rx2f_data_0_1_2", {8'h0, rxq[0][7:0], rxq[1][7:0], rxq[2][7:0]}, 32'h00A0A1A2);
            chk("rx2f_data_3_4", {16'h0, rxq[3][7:0], rxq[4][7:0]}, 32'h0000B0B1);
        end

        // ---------------- RX glitch and framing error ----------------
        rxq.delete();
        rxt.delete();
        rxd = 1'b0;
        tick(BIT / 2 - 3);
        rxd = 1'b1;
        tick((IDLE_BITS + 4) * BIT);
        chk("rx_glitch_no_output", rxq.size(), 0);
        uart_send(8'h55, 1'b0);
        tick(2 * BIT);
        uart_send(8'h3C, 1'b1);
        tick((IDLE_BITS + 4) * BIT);
        chk("rx_ferr_count", rxq.size(), 1);
        if (rxq.size() == 1) chk("rx_ferr_next_byte", {23'b0, rxq[0]}, {23'b0, 1'b1, 8'h3C});

        // ---------------- reset mid-transfer ----------------
        rxq.delete();
        rxt.delete();
        tx_data = 32'hDEAD_BEEF;
        tx_vld  = 1'b1;
        rxd     = 1'b0;
        tick(1);
        tx_vld  = 1'b0;
        tick(3 * BIT);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_txd", {31'b0, txd}, 32'd1);
        chk("rst_mid_rx_outputs", {22'b0, rx_vld, rx_last, rx_data}, 32'h0);
        rxd = 1'b1;
        tick(4);
        rst_n = 1'b1;
        lo = 0;
        for (int i = 0; i < (IDLE_BITS + 6) * BIT; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lo++;
        end
        chk("rst_post_txd_idle", lo, 0);
        chk("rst_post_no_rx_vld", rxq.size(), 0);
        tx_data = 32'h1234_5678;
        tx_vld  = 1'b1;
        tick(1);
        tx_vld  = 1'b0;
        exp_word = 32'h1234_5678;
        for (int j = 3; j >= 0; j--) begin
            uart_recv(1'b0, b, ok);
            chk($sformatf("rst_post_word_b%0d", 3 - j), {23'b0, ok, b},
                {23'b0, 1'b1, exp_word[8*j +: 8]});
        end
        chk("rx_last_without_vld", stray_last, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
